// File: rtl/seg_digit_scan.sv
// Time-multiplexed scan driver for a row of 7-segment digits: one octal digit per
// slot on b/en/sel, fed by a one-entry load buffer that only commits at frame boundaries.
module seg_digit_scan #(
    parameter int NDIG     = 4,
    parameter int DIV      = 1000,
    parameter bit BLANK_LZ = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_valid,
    input  logic [3*NDIG-1:0] load_data,
    output logic              load_ready,
    input  logic              disp_en,
    output logic [2:0]        b,
    output logic              en,
    output logic [NDIG-1:0]   sel
);

    localparam int PCW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int IDXW = $clog2(NDIG);

    logic [PCW-1:0]    pc_q, pc_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic [3*NDIG-1:0] act_q, act_d;
    logic [3*NDIG-1:0] pend_q, pend_d;
    logic              pv_q, pv_d;
    logic [2:0]        b_q, b_d;
    logic              en_q, en_d;
    logic [NDIG-1:0]   sel_q, sel_d;

    logic              tick;
    logic              boundary;
    logic              accept;
    logic [NDIG-1:0]   zero_above;

    // Load handshake: valid/ready; a transfer happens on a rising edge where
    // load_valid && load_ready. Ready is simply "pending buffer empty".
    assign load_ready = ~pv_q;
    assign accept     = load_valid && ~pv_q;

    assign tick     = (pc_q == PCW'(DIV - 1));
    assign boundary = tick && (idx_q == IDXW'(NDIG - 1));

    // zero_above[i] is set when digits i..NDIG-1 of the active word are all zero.
    always_comb begin : blank_scan
        zero_above         = '0;
        zero_above[NDIG-1] = (act_q[3*NDIG-1 -: 3] == 3'd0);
        for (int i = NDIG - 2; i >= 0; i--) begin
            zero_above[i] = zero_above[i+1] && (act_q[3*i +: 3] == 3'd0);
        end
    end

    always_comb begin : scan_next
        pc_d   = tick ? '0 : pc_q + 1'b1;
        idx_d  = idx_q;
        act_d  = act_q;
        pend_d = pend_q;
        pv_d   = pv_q;

        if (tick) begin
            idx_d = boundary ? '0 : idx_q + 1'b1;
        end

        // Commit and accept are exclusive: accept needs pv=0, commit needs pv=1.
        if (boundary && pv_q) begin
            act_d = pend_q;
            pv_d  = 1'b0;
        end
        if (accept) begin
            pend_d = load_data;
            pv_d   = 1'b1;
        end
    end

    always_comb begin : out_next
        b_d   = 3'd0;
        en_d  = 1'b0;
        sel_d = '1;
        for (int i = 0; i < NDIG; i++) begin
            if (idx_q == IDXW'(i)) begin
                b_d      = act_q[3*i +: 3];
                sel_d[i] = 1'b0;
                en_d     = disp_en && !(BLANK_LZ && (i != 0) && zero_above[i]);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q   <= '0;
            idx_q  <= '0;
            act_q  <= '0;
            pend_q <= '0;
            pv_q   <= 1'b0;
            b_q    <= 3'd0;
            en_q   <= 1'b0;
            sel_q  <= '1;
        end else begin
            pc_q   <= pc_d;
            idx_q  <= idx_d;
            act_q  <= act_d;
            pend_q <= pend_d;
            pv_q   <= pv_d;
            b_q    <= b_d;
            en_q   <= en_d;
            sel_q  <= sel_d;
        end
    end

    assign b   = b_q;
    assign en  = en_q;
    assign sel = sel_q;

endmodule

// File: tb/tb_seg_digit_scan.sv
// Bench for seg_digit_scan: two instances (leading-zero blanking on and off)
// share the same stimulus and are checked against a frame-level reference model.
module tb_seg_digit_scan;

    localparam int NDIG  = 4;
    localparam int DIV   = 4;
    localparam int W     = 3 * NDIG;
    localparam int FRAME = NDIG * DIV;

    localparam logic [17:0] RST_VEC   = {3'd0, 1'b0, 4'b1111, 1'b1, 3'd0, 1'b0, 4'b1111, 1'b1};
    localparam logic [17:0] FIRST_VEC = {3'd0, 1'b1, 4'b1110, 1'b1, 3'd0, 1'b1, 4'b1110, 1'b1};

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          load_valid = 1'b0;
    logic [W-1:0]  load_data = '0;
    logic          disp_en = 1'b1;

    logic          rdy1, rdy0;
    logic [2:0]    b1, b0;
    logic          en1, en0;
    logic [NDIG-1:0] sel1, sel0;
    logic [17:0]   obs;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    seg_digit_scan #(.NDIG(NDIG), .DIV(DIV), .BLANK_LZ(1'b1)) dut (
        .clk(clk), .rst(rst), .load_valid(load_valid), .load_data(load_data),
        .load_ready(rdy1), .disp_en(disp_en), .b(b1), .en(en1), .sel(sel1)
    );

    seg_digit_scan #(.NDIG(NDIG), .DIV(DIV), .BLANK_LZ(1'b0)) dut0 (
        .clk(clk), .rst(rst), .load_valid(load_valid), .load_data(load_data),
        .load_ready(rdy0), .disp_en(disp_en), .b(b0), .en(en0), .sel(sel0)
    );

    assign obs = {b1, en1, sel1, rdy1, b0, en0, sel0, rdy0};

    // Reference model: m_k counts rising edges since reset release; the slot shown
    // after edge k is (k/DIV)%NDIG and edge k is a frame boundary when (k+1)%FRAME==0.
    int            m_k = 0;
    int            m_slot = 0;
    int            m_acc = 0;
    logic [W-1:0]  m_act = '0;
    logic [W-1:0]  m_pend = '0;
    logic          m_pv = 1'b0;
    logic          m_take;
    logic [2:0]    e_b = 3'd0;
    logic          e_en = 1'b0;
    logic          e_en0 = 1'b0;
    logic [NDIG-1:0] e_sel = '1;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_k = 0; m_slot = 0; m_act = '0; m_pend = '0; m_pv = 1'b0;
            e_b = 3'd0; e_en = 1'b0; e_en0 = 1'b0; e_sel = '1;
        end else begin
            m_slot = (m_k / DIV) % NDIG;
            e_b    = 3'((m_act >> (3 * m_slot)) & 7);
            e_sel  = ~(NDIG'(1) << m_slot);
            e_en0  = disp_en;
            e_en   = disp_en && !((m_slot != 0) && ((m_act >> (3 * m_slot)) == 0));
            m_take = load_valid && !m_pv;
            if ((((m_k + 1) % FRAME) == 0) && m_pv) begin
                m_act = m_pend;
                m_pv  = 1'b0;
            end
            if (m_take) begin
                m_pend = load_data;
                m_pv   = 1'b1;
                m_acc++;
            end
            m_k++;
        end
    end

    function automatic logic [17:0] exp_vec();
        return {e_b, e_en, e_sel, ~m_pv, e_b, e_en0, e_sel, ~m_pv};
    endfunction

    function automatic int shown_slot();
        return ((m_k - 1) / DIV) % NDIG;
    endfunction

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if (obs !== RST_VEC) begin
            failures++;
            $display("FAIL reset_state got=%h exp=%h", obs, RST_VEC);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (obs !== FIRST_VEC) begin
            failures++;
            $display("FAIL reset_first_update got=%h exp=%h", obs, FIRST_VEC);
        end
    endtask

    task automatic test_scan();
        logic [3:0] sel_tab [4];
        sel_tab = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        disp_en = 1'b1;
        repeat (2 * FRAME) begin
            @(negedge clk);
            checks++;
            if (obs !== exp_vec()) begin
                failures++;
                $display("FAIL scan_model k=%0d got=%h exp=%h", m_k, obs, exp_vec());
            end
            checks++;
            if (sel1 !== sel_tab[shown_slot()]) begin
                failures++;
                $display("FAIL scan_sel k=%0d got=%b exp=%b", m_k, sel1, sel_tab[shown_slot()]);
            end
        end
    endtask

    task automatic test_load_blank();
        int start, n;
        logic [2:0] b_tab [4];
        logic en_tab [4];
        b_tab  = '{3'd3, 3'd5, 3'd0, 3'd0};
        en_tab = '{1'b1, 1'b1, 1'b0, 1'b0};
        start = m_acc;
        load_valid = 1'b1;
        load_data  = 12'o0053;
        n = 0;
        while (m_acc == start && n < 4 * FRAME) begin
            @(negedge clk);
            n++;
        end
        load_valid = 1'b0;
        checks++;
        if (m_acc == start) begin
            failures++;
            $display("FAIL load_blank_accept got=timeout exp=accept");
        end
        repeat (2 * FRAME) begin
            @(negedge clk);
            checks++;
            if (obs !== exp_vec()) begin
                failures++;
                $display("FAIL load_blank_model k=%0d got=%h exp=%h", m_k, obs, exp_vec());
            end
        end
        repeat (FRAME) begin
            @(negedge clk);
            checks++;
            if ({b1, en1, b0, en0} !== {b_tab[shown_slot()], en_tab[shown_slot()], b_tab[shown_slot()], 1'b1}) begin
                failures++;
                $display("FAIL load_blank_slot slot=%0d got=%b exp=%b", shown_slot(), {b1, en1, b0, en0},
                         {b_tab[shown_slot()], en_tab[shown_slot()], b_tab[shown_slot()], 1'b1});
            end
        end
    endtask

    task automatic test_back_to_back();
        int start, n;
        start = m_acc;
        load_valid = 1'b1;
        load_data  = 12'o1234;
        n = 0;
        while (m_acc == start && n < 4 * FRAME) begin
            @(negedge clk);
            n++;
        end
        load_data = 12'o7777;
        n = 0;
        while (m_acc == start + 1 && n < 4 * FRAME) begin
            checks++;
            if (obs !== exp_vec()) begin
                failures++;
                $display("FAIL backpressure_model k=%0d got=%h exp=%h", m_k, obs, exp_vec());
            end
            @(negedge clk);
            n++;
        end
        load_valid = 1'b0;
        checks++;
        if (m_acc != start + 2) begin
            failures++;
            $display("FAIL backpressure_accepts got=%0d exp=%0d", m_acc - start, 2);
        end
        repeat (3 * FRAME) begin
            @(negedge clk);
            checks++;
            if (obs !== exp_vec()) begin
                failures++;
                $display("FAIL back_to_back_model k=%0d got=%h exp=%h", m_k, obs, exp_vec());
            end
        end
    endtask

    task automatic test_no_tearing();
        int start, n;
        logic [2:0] new_tab [4];
        new_tab = '{3'd7, 3'd6, 3'd5, 3'd4};
        n = 0;
        while ((shown_slot() != 2 || m_pv) && n < 4 * FRAME) begin
            @(negedge clk);
            n++;
        end
        start = m_acc;
        load_valid = 1'b1;
        load_data  = 12'o4567;
        @(negedge clk);
        load_valid = 1'b0;
        checks++;
        if (m_acc != start + 1) begin
            failures++;
            $display("FAIL tearing_accept got=%0d exp=1", m_acc - start);
        end
        n = 0;
        while ((m_k % FRAME) != 0 && n < FRAME) begin
            checks++;
            if (b1 !== 3'd7) begin
                failures++;
                $display("FAIL tearing_old slot=%0d got=%0d exp=7", shown_slot(), b1);
            end
            @(negedge clk);
            n++;
        end
        checks++;
        if (b1 !== 3'd7) begin
            failures++;
            $display("FAIL tearing_last_old got=%0d exp=7", b1);
        end
        repeat (FRAME) begin
            @(negedge clk);
            checks++;
            if (b1 !== new_tab[shown_slot()] || obs !== exp_vec()) begin
                failures++;
                $display("FAIL tearing_new slot=%0d got=%h exp_b=%0d exp=%h", shown_slot(), obs,
                         new_tab[shown_slot()], exp_vec());
            end
        end
    endtask

    task automatic test_boundary_load();
        int n;
        logic [2:0] old_tab [4];
        logic [2:0] new_tab [4];
        logic en_tab [4];
        old_tab = '{3'd7, 3'd6, 3'd5, 3'd4};
        new_tab = '{3'd0, 3'd2, 3'd1, 3'd0};
        en_tab  = '{1'b1, 1'b1, 1'b1, 1'b0};
        n = 0;
        while (((m_k % FRAME) != FRAME - 1 || m_pv) && n < 4 * FRAME) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (rdy1 !== 1'b1) begin
            failures++;
            $display("FAIL boundary_ready got=%b exp=1", rdy1);
        end
        load_valid = 1'b1;
        load_data  = 12'o0120;
        @(negedge clk);
        load_valid = 1'b0;
        checks++;
        if (rdy1 !== 1'b0 || b1 !== 3'd4) begin
            failures++;
            $display("FAIL boundary_accept got_rdy=%b got_b=%0d exp_rdy=0 exp_b=4", rdy1, b1);
        end
        repeat (FRAME) begin
            @(negedge clk);
            checks++;
            if (b1 !== old_tab[shown_slot()] || obs !== exp_vec()) begin
                failures++;
                $display("FAIL boundary_hold slot=%0d got=%h exp_b=%0d", shown_slot(), obs, old_tab[shown_slot()]);
            end
        end
        repeat (FRAME) begin
            @(negedge clk);
            checks++;
            if ({b1, en1} !== {new_tab[shown_slot()], en_tab[shown_slot()]}) begin
                failures++;
                $display("FAIL boundary_commit slot=%0d got=%b exp=%b", shown_slot(), {b1, en1},
                         {new_tab[shown_slot()], en_tab[shown_slot()]});
            end
        end
    endtask

    task automatic test_disp_en();
        disp_en = 1'b0;
        @(negedge clk);
        checks++;
        if ({en1, en0} !== 2'b00) begin
            failures++;
            $display("FAIL disp_en_off got=%b exp=00", {en1, en0});
        end
        repeat (FRAME) begin
            @(negedge clk);
            checks++;
            if (obs !== exp_vec()) begin
                failures++;
                $display("FAIL disp_en_dark k=%0d got=%h exp=%h", m_k, obs, exp_vec());
            end
        end
        disp_en = 1'b1;
        repeat (FRAME) begin
            @(negedge clk);
            checks++;
            if (obs !== exp_vec()) begin
                failures++;
                $display("FAIL disp_en_on k=%0d got=%h exp=%h", m_k, obs, exp_vec());
            end
        end
    endtask

    task automatic test_reset_mid();
        int start, n;
        n = 0;
        while (((m_k % FRAME) != 2 || m_pv) && n < 4 * FRAME) begin
            @(negedge clk);
            n++;
        end
        start = m_acc;
        load_valid = 1'b1;
        load_data  = 12'o7654;
        @(negedge clk);
        load_valid = 1'b0;
        repeat (5) @(negedge clk);
        checks++;
        if (rdy1 !== 1'b0 || m_acc != start + 1) begin
            failures++;
            $display("FAIL reset_mid_setup got_rdy=%b exp_rdy=0", rdy1);
        end
        #2;
        rst = 1'b1;
        load_valid = 1'b1;
        load_data  = 12'o7777;
        #1;
        checks++;
        if (obs !== RST_VEC) begin
            failures++;
            $display("FAIL reset_mid_async got=%h exp=%h", obs, RST_VEC);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (obs !== RST_VEC) begin
            failures++;
            $display("FAIL reset_mid_held got=%h exp=%h", obs, RST_VEC);
        end
        rst = 1'b0;
        load_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (obs !== FIRST_VEC) begin
            failures++;
            $display("FAIL reset_mid_first got=%h exp=%h", obs, FIRST_VEC);
        end
        repeat (2 * FRAME) begin
            @(negedge clk);
            checks++;
            if (obs !== exp_vec()) begin
                failures++;
                $display("FAIL reset_mid_model k=%0d got=%h exp=%h", m_k, obs, exp_vec());
            end
        end
    endtask

    task automatic test_random();
        int last_acc;
        last_acc = m_acc;
        repeat (800) begin
            @(negedge clk);
            checks++;
            if (obs !== exp_vec()) begin
                failures++;
                $display("FAIL random k=%0d got=%h exp=%h", m_k, obs, exp_vec());
            end
            if (load_valid && m_acc != last_acc) begin
                load_valid = 1'b0;
            end
            last_acc = m_acc;
            if (!load_valid && $urandom_range(0, 3) == 0) begin
                load_valid = 1'b1;
                load_data  = W'($urandom);
            end else if (load_valid && !m_pv == 1'b0 && $urandom_range(0, 1) == 0) begin
                load_data = W'($urandom);
            end
            if ($urandom_range(0, 15) == 0) begin
                disp_en = ~disp_en;
            end
        end
        load_valid = 1'b0;
        disp_en = 1'b1;
    endtask

    initial begin
        test_reset();
        test_scan();
        test_load_blank();
        test_back_to_back();
        test_no_tearing();
        test_boundary_load();
        test_disp_en();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
